// File: rtl/rv32_alu_issue_if.sv
// Issue/writeback channel bundle between the ALU issue stage and its neighbours.
// The slave modport is the issue block's view; master is the surrounding logic's view.
interface rv32_alu_issue_if;
  logic        in_valid_in;
  logic        in_ready_out;
  logic [2:0]  funct3_in;
  logic        funct7_5_in;
  logic        is_imm_in;
  logic [31:0] rs1_data_in;
  logic [31:0] rs2_data_in;
  logic [31:0] imm_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] alu_op_1_out;
  logic [31:0] alu_op_2_out;
  logic [3:0]  alu_opcode_out;
  logic [31:0] alu_result_in;
  logic        out_valid_out;
  logic        out_ready_in;
  logic [31:0] out_result_out;
  logic [4:0]  out_rd_addr_out;
  logic [15:0] op_count_out;

  modport slave (
    input  in_valid_in, funct3_in, funct7_5_in, is_imm_in, rs1_data_in,
           rs2_data_in, imm_in, rd_addr_in, alu_result_in, out_ready_in,
    output in_ready_out, alu_op_1_out, alu_op_2_out, alu_opcode_out,
           out_valid_out, out_result_out, out_rd_addr_out, op_count_out
  );

  modport master (
    output in_valid_in, funct3_in, funct7_5_in, is_imm_in, rs1_data_in,
           rs2_data_in, imm_in, rd_addr_in, alu_result_in, out_ready_in,
    input  in_ready_out, alu_op_1_out, alu_op_2_out, alu_opcode_out,
           out_valid_out, out_result_out, out_rd_addr_out, op_count_out
  );
endinterface

// File: rtl/rv32_alu_issue.sv
// Two-stage RV32 integer ALU issue pipeline: S1 holds operands/opcode for an
// external combinational ALU, S2 captures its result for the writeback channel.
module rv32_alu_issue (
  input  logic            clk_in,
  input  logic            rst_n_in,
  rv32_alu_issue_if.slave bus
);

  logic [31:0] r_op1_p1;
  logic [31:0] r_op2_p1;
  logic [3:0]  r_opc_p1;
  logic [4:0]  r_rd_p1;
  logic        r_vld_p1;

  logic [31:0] r_res_p2;
  logic [4:0]  r_rd_p2;
  logic        r_vld_p2;

  logic [15:0] r_cnt;

  logic        w_adv_p1;
  logic        w_drain_p2;
  logic        w_in_ready;
  logic        w_accept;
  logic [3:0]  w_opc;
  logic [31:0] w_op2;

  // Bit 3 selects SUB/SRA; OP-IMM never produces SUB, so ADDI ignores imm[10].
  function automatic logic [3:0] f_alu_opcode(input logic [2:0] funct3,
                                              input logic       funct7_5,
                                              input logic       is_imm,
                                              input logic       imm_10);
    logic bit3;
    if (is_imm) bit3 = (funct3 == 3'b101) & imm_10;
    else        bit3 = ((funct3 == 3'b000) | (funct3 == 3'b101)) & funct7_5;
    return {bit3, funct3};
  endfunction

  always_comb begin
    w_drain_p2 = r_vld_p2 & bus.out_ready_in;
    w_adv_p1   = r_vld_p1 & (~r_vld_p2 | bus.out_ready_in);
    w_in_ready = ~r_vld_p1 | w_adv_p1;
    w_accept   = bus.in_valid_in & w_in_ready;
    w_opc      = f_alu_opcode(bus.funct3_in, bus.funct7_5_in, bus.is_imm_in, bus.imm_in[10]);
    w_op2      = bus.is_imm_in ? bus.imm_in : bus.rs2_data_in;
  end

  // ---- stage 1: operand/opcode register feeding the ALU
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_vld_p1 <= 1'b0;
      r_op1_p1 <= '0;
      r_op2_p1 <= '0;
      r_opc_p1 <= '0;
      r_rd_p1  <= '0;
    end else if (w_accept) begin
      r_vld_p1 <= 1'b1;
      r_op1_p1 <= bus.rs1_data_in;
      r_op2_p1 <= w_op2;
      r_opc_p1 <= w_opc;
      r_rd_p1  <= bus.rd_addr_in;
    end else if (w_adv_p1) begin
      r_vld_p1 <= 1'b0;
    end
  end

  // ---- stage 2: result register; x0 writes always carry zero
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_vld_p2 <= 1'b0;
      r_res_p2 <= '0;
      r_rd_p2  <= '0;
    end else if (w_adv_p1) begin
      r_vld_p2 <= 1'b1;
      r_res_p2 <= (r_rd_p1 == 5'd0) ? 32'd0 : bus.alu_result_in;
      r_rd_p2  <= r_rd_p1;
    end else if (w_drain_p2) begin
      r_vld_p2 <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)       r_cnt <= '0;
    else if (w_drain_p2) r_cnt <= r_cnt + 16'd1;
  end

  assign bus.in_ready_out    = w_in_ready;
  assign bus.alu_op_1_out    = r_op1_p1;
  assign bus.alu_op_2_out    = r_op2_p1;
  assign bus.alu_opcode_out  = r_opc_p1;
  assign bus.out_valid_out   = r_vld_p2;
  assign bus.out_result_out  = r_res_p2;
  assign bus.out_rd_addr_out = r_rd_p2;
  assign bus.op_count_out    = r_cnt;

endmodule

// File: doc/rv32_alu_issue.md
RV32_ALU_ISSUE -- requirements
Module: rv32_alu_issue

Interface
REQ-001 SHALL have ports: clk_in  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: in_valid_in  input  1  decoded instruction present; in_ready_out  output  1  block can accept.
REQ-004 SHALL have ports: funct3_in  input  3  instruction funct3; funct7_5_in  input  1  instruction bit 30; is_imm_in  input  1  OP-IMM (1) vs OP (0).
REQ-005 SHALL have ports: rs1_data_in  input  32; rs2_data_in  input  32; imm_in  input  32  sign-extended immediate; rd_addr_in  input  5  destination register.
REQ-006 SHALL have ports: alu_op_1_out  output  32; alu_op_2_out  output  32; alu_opcode_out  output  4  drive the combinational rv32_alu; alu_result_in  input  32  ALU result_out.
REQ-007 SHALL have ports: out_valid_out  output  1; out_ready_in  input  1; out_result_out  output  32; out_rd_addr_out  output  5  writeback channel.
REQ-008 SHALL have ports: op_count_out  output  16  count of results accepted downstream.

Function
REQ-009 SHALL implement a two-stage pipeline: S1 (operand/opcode register feeding the ALU) and S2 (result register), each with a valid flag.
REQ-010 SHALL form ALU opcode {bit3, funct3_in}: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
REQ-011 SHALL set bit3 for OP as funct7_5_in when funct3_in is 000 or 101, else 0.
REQ-012 SHALL set bit3 for OP-IMM as imm_in[10] when funct3_in is 101, else 0 (ADDI never becomes SUB).
REQ-013 SHALL select op_2 = imm_in when is_imm_in=1, else rs2_data_in; op_1 = rs1_data_in always.
REQ-014 SHALL accept an instruction on a rising edge where in_valid_in and in_ready_out are both 1, loading S1.
REQ-015 SHALL drive alu_op_1_out, alu_op_2_out, alu_opcode_out directly from S1 registers; values held stable while S1 is stalled or empty.
REQ-016 SHALL advance S1 to S2 (capturing alu_result_in and rd) when S1 valid and (S2 empty or out_ready_in=1).
REQ-017 SHALL compute in_ready_out = !S1_valid or S1 advancing this cycle (combinational, no dependence on in_valid_in).
REQ-018 SHALL drive out_valid_out from S2 valid; out_result_out, out_rd_addr_out from S2 registers, stable while out_valid_out=1 and out_ready_in=0.
REQ-019 SHALL force S2 result to 0 when rd is 0.
REQ-020 SHALL have latency 2 edges: instruction accepted at edge N appears with out_valid_out=1 after edge N+1 when not stalled.
REQ-021 SHALL sustain one instruction per cycle when out_ready_in is held 1.
REQ-022 SHALL, on simultaneous S2 drain and S1 advance, replace S2 contents in the same edge without bubble.
REQ-023 SHALL, when both stages full and out_ready_in=0, hold all state and deassert in_ready_out.
REQ-024 SHALL increment op_count_out on every edge where out_valid_out and out_ready_in are 1, wrapping 0xFFFF to 0x0000.

Reset
REQ-025 SHALL, while rst_n_in=0, asynchronously clear S1/S2 valid flags, S1/S2 data registers, and op_count_out to 0.
REQ-026 SHALL, during reset, present out_valid_out=0, in_ready_out=1, alu_opcode_out=0000, all data outputs 0.
REQ-027 SHALL discard any in-flight instruction on reset mid-operation; no result is emitted after reset release.

Verification
REQ-028 ADD R-type: rs1=15, rs2=10, funct3=000, funct7_5=0, rd=3, out_ready=1 -> alu_opcode_out=0000, out_result_out=25, rd=3, out_valid 2 edges after accept.
REQ-029 SUB vs ADDI: OP funct7_5=1 funct3=000 rs1=15 rs2=10 -> opcode 1000, result 5; OP-IMM funct3=000 imm=0xFFFFFC00 rs1=15 -> opcode 0000, result 0xFFFFFC0F.
REQ-030 SRAI: rs1=0xFFFFFFF8, imm=0x402, funct3=101, is_imm=1 -> opcode 1101, result 0xFFFFFFFE; SRLI imm=0x002 rs1=8 -> opcode 0101, result 2.
REQ-031 Back-pressure: 3 back-to-back ops, out_ready=0 -> in_ready_out drops after 2 accepted, third held; raise out_ready -> results emerge in order, one per cycle, op_count_out=3.
REQ-032 rd=0 and wrap: ADD rs1=1 rs2=1 rd=0 -> out_result_out=0; preload 65535 handshakes -> next handshake gives op_count_out=0.
REQ-033 Reset mid-flight: assert rst_n_in=0 with both stages valid -> out_valid_out=0, op_count_out=0 immediately (asynchronous); after release, no stale result appears.
